// File: rtl/serial_shift_right_unit.sv
`timescale 1ns/1ps
// Iterative srl/sra/srlv/srav unit: shifts the operand right one bit per clock.
// Latency: DONE visible SHAMT+1 cycles after the accept edge (1 cycle for SHAMT=0).
// Backpressure: START is only taken while BUSY=0; requests during a shift are dropped.
module serial_shift_right_unit #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   START,
  input  logic                   ARITH,
  input  logic [DATA_WIDTH-1:0]  DATA_IN,
  input  logic [SHAMT_WIDTH-1:0] SHAMT,
  output logic                   BUSY,
  output logic                   DONE,
  output logic [DATA_WIDTH-1:0]  OUT
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam logic [SHAMT_WIDTH-1:0] CNT_ONE = SHAMT_WIDTH'(1);

  state_t                  state;
  state_t                  state_nxt;
  logic [DATA_WIDTH-1:0]   shift_reg;
  logic [DATA_WIDTH-1:0]   shift_nxt;
  logic [DATA_WIDTH-1:0]   out_reg;
  logic [SHAMT_WIDTH-1:0]  count;
  logic                    arith_fill;
  logic                    accept;
  logic                    last_shift;

  // A new request is taken in IDLE and also in FINISH, so back-to-back shifts lose no cycle.
  assign accept     = START && (state != SHIFT);
  assign last_shift = (state == SHIFT) && (count == CNT_ONE);

  // One-bit right shift; the fill bit replicates the sign only for arithmetic shifts.
  assign shift_nxt  = {arith_fill & shift_reg[DATA_WIDTH-1], shift_reg[DATA_WIDTH-1:1]};

  assign OUT = out_reg;

  // State register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    BUSY      = 1'b0;
    DONE      = 1'b0;
    case (state)
      IDLE, FINISH: begin
        DONE = (state == FINISH);
        if (START) begin
          // A zero shift amount completes without any shift cycles.
          state_nxt = (SHAMT == '0) ? FINISH : SHIFT;
        end else begin
          state_nxt = IDLE;
        end
      end
      SHIFT: begin
        BUSY = 1'b1;
        if (count == CNT_ONE) begin
          state_nxt = FINISH;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operand capture, iterative shifting and remaining-shift counter.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      shift_reg  <= '0;
      count      <= '0;
      arith_fill <= 1'b0;
    end else if (accept) begin
      shift_reg  <= DATA_IN;
      count      <= SHAMT;
      arith_fill <= ARITH;
    end else if (state == SHIFT) begin
      shift_reg  <= shift_nxt;
      count      <= count - CNT_ONE;
    end
  end

  // Result register: only loaded on the edge entering FINISH, so it holds the
  // previous result for the whole shift and is valid together with DONE.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      out_reg <= '0;
    end else if (accept && (SHAMT == '0)) begin
      out_reg <= DATA_IN;
    end else if (last_shift) begin
      out_reg <= shift_nxt;
    end
  end

endmodule

// File: tb/tb_serial_shift_right_unit.sv
`timescale 1ns/1ps
// Bench for serial_shift_right_unit: directed scenarios plus random operations
// compared against an arithmetic reference (>> and >>>) and a latency rule.
module tb_serial_shift_right_unit;

  logic        CLK;
  logic        RST;
  logic        START;
  logic        ARITH;
  logic [31:0] DATA_IN;
  logic [4:0]  SHAMT;
  logic        BUSY;
  logic        DONE;
  logic [31:0] OUT;

  int n_checks = 0;
  int n_fail   = 0;

  serial_shift_right_unit #(.DATA_WIDTH(32), .SHAMT_WIDTH(5)) dut (
    .CLK(CLK), .RST(RST), .START(START), .ARITH(ARITH),
    .DATA_IN(DATA_IN), .SHAMT(SHAMT), .BUSY(BUSY), .DONE(DONE), .OUT(OUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] ref_shift(input logic [31:0] d, input int s, input logic a);
    logic signed [31:0] sd;
    sd = d;
    if (a) return 32'(sd >>> s);
    return d >> s;
  endfunction

  function automatic int ref_cycles(input int s);
    return s + 1;
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Launch one shift and follow it to DONE (bounded); leaves time in the DONE cycle.
  task automatic do_shift(input logic [31:0] d, input int s, input logic a,
                          output int cycles, output logic [31:0] res,
                          output int busy_cnt, output bit out_moved);
    logic [31:0] prev_out;
    prev_out  = OUT;
    START     = 1'b1;
    DATA_IN   = d;
    SHAMT     = 5'(s);
    ARITH     = a;
    cycles    = 0;
    busy_cnt  = 0;
    out_moved = 1'b0;
    do begin
      step();
      cycles++;
      START   = 1'b0;
      DATA_IN = $urandom;
      SHAMT   = 5'($urandom_range(31, 0));
      ARITH   = 1'($urandom_range(1, 0));
      if (BUSY) busy_cnt++;
      if (!DONE && OUT !== prev_out) out_moved = 1'b1;
    end while (!DONE && cycles < 200);
    if (!DONE) cycles = -1;
    res = OUT;
  endtask

  task automatic test_reset();
    RST = 1'b1; START = 1'b0; ARITH = 1'b0; DATA_IN = '0; SHAMT = '0;
    #2;
    RST     = 1'b0;
    START   = 1'b1;
    DATA_IN = $urandom;
    SHAMT   = 5'($urandom_range(31, 1));
    ARITH   = 1'($urandom_range(1, 0));
    repeat (3) step();
    n_checks++;
    if ({BUSY, DONE, OUT} !== 34'h0) begin
      n_fail++;
      $display("FAIL reset_hold: busy=%b done=%b out=%h, expected 0 0 00000000", BUSY, DONE, OUT);
    end
    START = 1'b0;
    RST   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++;
      if ({BUSY, DONE, OUT} !== 34'h0) begin
        n_fail++;
        $display("FAIL reset_idle[%0d]: busy=%b done=%b out=%h, expected 0 0 00000000", i, BUSY, DONE, OUT);
      end
    end
  endtask

  task automatic test_logical();
    int cyc; int bc; bit mv; logic [31:0] r;
    do_shift(32'hF000_0000, 4, 1'b0, cyc, r, bc, mv);
    n_checks++;
    if (cyc !== 5) begin n_fail++; $display("FAIL logical_latency: got %0d expected 5", cyc); end
    n_checks++;
    if (r !== 32'h0F00_0000) begin n_fail++; $display("FAIL logical_out: got %h expected 0f000000", r); end
    n_checks++;
    if (bc !== 4) begin n_fail++; $display("FAIL logical_busy: got %0d cycles expected 4", bc); end
    n_checks++;
    if (mv !== 1'b0) begin n_fail++; $display("FAIL logical_out_stable: OUT changed during shift"); end
    step();
    n_checks++;
    if ({BUSY, DONE} !== 2'b00) begin
      n_fail++;
      $display("FAIL logical_done_pulse: busy=%b done=%b expected 0 0", BUSY, DONE);
    end
  endtask

  task automatic test_arith();
    int cyc; int bc; bit mv; logic [31:0] r;
    do_shift(32'h8000_0000, 31, 1'b1, cyc, r, bc, mv);
    n_checks++;
    if (cyc !== 32) begin n_fail++; $display("FAIL sra31_latency: got %0d expected 32", cyc); end
    n_checks++;
    if (r !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sra31_out: got %h expected ffffffff", r); end
    step();
    do_shift(32'h8000_0000, 31, 1'b0, cyc, r, bc, mv);
    n_checks++;
    if (cyc !== 32) begin n_fail++; $display("FAIL srl31_latency: got %0d expected 32", cyc); end
    n_checks++;
    if (r !== 32'h0000_0001) begin n_fail++; $display("FAIL srl31_out: got %h expected 00000001", r); end
    n_checks++;
    if (bc !== 31) begin n_fail++; $display("FAIL srl31_busy: got %0d expected 31", bc); end
    step();
  endtask

  task automatic test_zero_back_to_back();
    int cyc; int bc; bit mv; logic [31:0] r;
    do_shift(32'h1234_5678, 0, 1'($urandom_range(1, 0)), cyc, r, bc, mv);
    n_checks++;
    if (cyc !== 1) begin n_fail++; $display("FAIL zero_latency: got %0d expected 1", cyc); end
    n_checks++;
    if (r !== 32'h1234_5678) begin n_fail++; $display("FAIL zero_out: got %h expected 12345678", r); end
    // Still in the FINISH cycle: the next request must be taken right away.
    do_shift(32'h0000_0100, 8, 1'b0, cyc, r, bc, mv);
    n_checks++;
    if (cyc !== 9) begin n_fail++; $display("FAIL b2b_latency: got %0d expected 9", cyc); end
    n_checks++;
    if (r !== 32'h0000_0001) begin n_fail++; $display("FAIL b2b_out: got %h expected 00000001", r); end
    n_checks++;
    if (mv !== 1'b0) begin n_fail++; $display("FAIL b2b_out_stable: OUT changed during shift"); end
    step();
  endtask

  task automatic test_ignore_busy();
    int cyc; int dones; int first_done; logic [31:0] r;
    START = 1'b1; DATA_IN = 32'hFFFF_0000; SHAMT = 5'd16; ARITH = 1'b0;
    dones = 0; first_done = -1; r = '0;
    for (cyc = 1; cyc <= 40; cyc++) begin
      step();
      START = 1'b0;
      if (cyc == 5) begin
        START = 1'b1; DATA_IN = 32'h1234_5678; SHAMT = 5'd3; ARITH = 1'b1;
      end
      if (DONE) begin
        dones++;
        if (first_done < 0) begin first_done = cyc; r = OUT; end
      end
    end
    START = 1'b0;
    n_checks++;
    if (dones !== 1) begin n_fail++; $display("FAIL busy_ignore_pulses: got %0d expected 1", dones); end
    n_checks++;
    if (first_done !== 17) begin n_fail++; $display("FAIL busy_ignore_latency: got %0d expected 17", first_done); end
    n_checks++;
    if (r !== 32'h0000_FFFF) begin n_fail++; $display("FAIL busy_ignore_out: got %h expected 0000ffff", r); end
  endtask

  task automatic test_reset_mid();
    int cyc; int bc; bit mv; int dones; logic [31:0] r;
    START = 1'b1; DATA_IN = $urandom | 32'h8000_0000; SHAMT = 5'd20; ARITH = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      step();
      START = 1'b0;
    end
    RST = 1'b0;
    #1;
    n_checks++;
    if ({BUSY, DONE, OUT} !== 34'h0) begin
      n_fail++;
      $display("FAIL midreset_abort: busy=%b done=%b out=%h, expected 0 0 00000000", BUSY, DONE, OUT);
    end
    step();
    RST = 1'b1;
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (DONE) dones++;
    end
    n_checks++;
    if (dones !== 0) begin n_fail++; $display("FAIL midreset_no_done: got %0d pulses expected 0", dones); end
    do_shift(32'h0000_0010, 4, 1'b0, cyc, r, bc, mv);
    n_checks++;
    if (r !== 32'h0000_0001) begin n_fail++; $display("FAIL midreset_after_out: got %h expected 00000001", r); end
    n_checks++;
    if (cyc !== 5) begin n_fail++; $display("FAIL midreset_after_latency: got %0d expected 5", cyc); end
    step();
  endtask

  task automatic test_random();
    int cyc; int bc; bit mv; logic [31:0] r; logic [31:0] d; int s; logic a; int gap;
    for (int n = 0; n < 40; n++) begin
      d = $urandom;
      s = $urandom_range(31, 0);
      a = 1'($urandom_range(1, 0));
      do_shift(d, s, a, cyc, r, bc, mv);
      n_checks++;
      if (r !== ref_shift(d, s, a)) begin
        n_fail++;
        $display("FAIL rand_out[%0d] d=%h s=%0d a=%b: got %h expected %h", n, d, s, a, r, ref_shift(d, s, a));
      end
      n_checks++;
      if (cyc !== ref_cycles(s)) begin
        n_fail++;
        $display("FAIL rand_latency[%0d] s=%0d: got %0d expected %0d", n, s, cyc, ref_cycles(s));
      end
      n_checks++;
      if (bc !== s) begin n_fail++; $display("FAIL rand_busy[%0d]: got %0d expected %0d", n, bc, s); end
      n_checks++;
      if (mv !== 1'b0) begin n_fail++; $display("FAIL rand_out_stable[%0d]: OUT changed during shift", n); end
      gap = $urandom_range(2, 0);
      for (int g = 0; g < gap; g++) begin
        step();
        n_checks++;
        if (DONE !== 1'b0) begin n_fail++; $display("FAIL rand_idle_done[%0d]: got %b expected 0", n, DONE); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_logical();
    test_arith();
    test_zero_back_to_back();
    test_ignore_busy();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_shift_right_unit.md
Name: serial_shift_right_unit

Overview:
- Iterative right-shift unit for the MIPS datapath. It is the opposite direction of the fixed left-shift used in PC and offset handling.
- Executes srl/sra (and the variable forms srlv/srav) one bit per clock under a START/DONE handshake.
- Sits beside the ALU. The control unit launches a shift and stalls until DONE.

Parameters:
- DATA_WIDTH, 32, operand and result width in bits.
- SHAMT_WIDTH, 5, width of the shift-amount field; the maximum shift is 2^SHAMT_WIDTH - 1.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-low reset.
- START  input  1  request a shift; sampled only while BUSY=0.
- ARITH  input  1  1 = arithmetic (sign fill), 0 = logical (zero fill); sampled with START.
- DATA_IN  input  DATA_WIDTH  operand; sampled with START.
- SHAMT  input  SHAMT_WIDTH  shift amount; sampled with START.
- BUSY  output  1  high while a shift is in progress.
- DONE  output  1  one-cycle pulse when OUT is valid.
- OUT  output  DATA_WIDTH  shift result; holds its value until the next accepted START.

Behaviour:
- Reset (RST=0, asynchronous):
  - State goes to IDLE.
  - OUT, the internal shift register and the counter clear to 0.
  - BUSY=0, DONE=0.
  - Release from reset is synchronous to CLK.
- States:
  - IDLE: BUSY=0, DONE=0.
  - SHIFT: BUSY=1, DONE=0.
  - FINISH: BUSY=0, DONE=1.
- IDLE or FINISH with START=1 (accept):
  - Latch DATA_IN into the shift register, SHAMT into the counter, and ARITH into the fill bit.
  - Go to SHIFT if SHAMT != 0; go to FINISH if SHAMT == 0 (result = DATA_IN).
- IDLE or FINISH with START=0: go to (or stay in) IDLE.
- SHIFT, each cycle:
  - Shift register <= {fill, reg[DATA_WIDTH-1:1]}, where fill = ARITH ? reg[DATA_WIDTH-1] : 0.
  - Counter decrements by 1.
  - When the counter reaches 1 (the last shift), go to FINISH.
- Entering FINISH: OUT loads the final register value on the same edge, so OUT is valid in the same cycle DONE=1.
- Latency:
  - From the START-accept edge to DONE high: SHAMT+1 cycles for SHAMT>=1, and 1 cycle for SHAMT=0.
  - DONE is high for exactly one cycle.
- Back-to-back: START asserted during the FINISH cycle is accepted. DONE still pulses for the old result and OUT updates at the next completion.
- START while BUSY=1 is ignored. DATA_IN, SHAMT and ARITH changes during SHIFT have no effect.
- SHAMT = max (31): 31 shift cycles.
  - Logical: only bit 31 survives, moved to bit 0.
  - Arithmetic: result is all sign bits.
- Reset asserted mid-SHIFT: abort immediately to the reset values. No DONE is produced for the aborted operation.
- OUT does not change during SHIFT; it shows the previous result until FINISH.

Test Plan:
- Reset: hold RST=0 with random inputs -> BUSY=0, DONE=0, OUT=0x00000000. Release and idle 5 cycles -> all outputs unchanged.
- Logical shift: DATA_IN=0xF0000000, SHAMT=4, ARITH=0, pulse START -> BUSY=1 for 4 cycles, DONE on the 5th cycle after accept, OUT=0x0F000000.
- Arithmetic shift: DATA_IN=0x80000000, SHAMT=31, ARITH=1 -> DONE 32 cycles after accept, OUT=0xFFFFFFFF. The same operand with ARITH=0 -> OUT=0x00000001.
- Zero shift plus back-to-back:
  - DATA_IN=0x12345678, SHAMT=0 -> DONE exactly 1 cycle after accept, OUT=0x12345678.
  - START in that FINISH cycle with 0x00000100, SHAMT=8, ARITH=0 -> accepted; next DONE 9 cycles later with OUT=0x00000001.
- Ignore while busy: START 0xFFFF0000, SHAMT=16, ARITH=0. Re-pulse START with a different DATA_IN/SHAMT on cycle 5 -> ignored; OUT=0x0000FFFF, only one DONE pulse.
- Reset mid-operation: start SHAMT=20, drive RST=0 on cycle 7 -> immediate BUSY=0, OUT=0, and no DONE afterward. A following START with 0x00000010, SHAMT=4 -> OUT=0x00000001.
